// File: rtl/flow_light_ctrl_pkg.sv
// Command and state codes shared by the flowing-light sequencer and the display
// datapath, plus the speed-to-period helper used by the prescaler.
package flow_light_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_HOLD   = 2'b00,
        DIR_SHR    = 2'b01,
        DIR_SHL    = 2'b10,
        DIR_RELOAD = 2'b11
    } dir_cmd_e;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    // Speed 3 steps every base_div cycles; each lower speed doubles the period.
    function automatic int unsigned period_cycles(input int unsigned base_div,
                                                  input logic [1:0]  speed);
        return base_div << (2'd3 - speed);
    endfunction

endpackage

// File: rtl/flow_light_ctrl_if.sv
// Command bundle from the sequencer to the 16-LED display register.
interface flow_light_ctrl_if #(
    parameter int NUM_LEDS = 16
);
    localparam int POS_W = $clog2(NUM_LEDS);

    logic [1:0]       Dir_Sel;
    logic             Step;
    logic             Mode;
    logic [POS_W-1:0] Pos;

    modport master (output Dir_Sel, Step, Mode, Pos);
    modport slave  (input  Dir_Sel, Step, Mode, Pos);

endinterface

// File: rtl/flow_light_ctrl_button_debounce.sv
// Push-button conditioner: 2-FF synchroniser, then a level that only follows
// the synced input after it has differed from it for DB_CYCLES straight cycles.
module button_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic btn_raw,
    output logic btn_level
);
    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    logic [CNT_W-1:0] cnt;

    assign btn_s = sync_q[1];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_q    <= '0;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            // Any bounce back to the accepted level restarts the stability window.
            if (btn_s == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                btn_level <= btn_s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/flow_light_ctrl.sv
// Flowing-light sequencer: switch synchronisers, speed prescaler and the
// load/run/pause mode FSM that commands the display register.
module flow_light_ctrl
    import flow_light_ctrl_pkg::*;
#(
    parameter int BASE_DIV  = 6_250_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int NUM_LEDS  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        speed,
    input  logic              RLSwitch,
    input  logic              PauseSwitch,
    input  logic              Button_mid,
    flow_light_ctrl_if.master disp
);
    localparam int               CNT_W    = $clog2(BASE_DIV << 3);
    localparam int               POS_W    = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    // ---------------- input conditioning ----------------
    logic [3:0] sync_meta;
    logic [3:0] sync_q;
    logic [1:0] speed_s;
    logic [1:0] speed_q;
    logic       rl_s;
    logic       pause_s;
    logic       btn_level;
    logic       btn_level_q;
    logic       press;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sync_meta   <= '0;
            sync_q      <= '0;
            speed_q     <= '0;
            btn_level_q <= 1'b0;
        end else begin
            sync_meta   <= {speed, RLSwitch, PauseSwitch};
            sync_q      <= sync_meta;
            speed_q     <= speed_s;
            btn_level_q <= btn_level;
        end
    end

    assign {speed_s, rl_s, pause_s} = sync_q;

    button_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .CLK       (CLK),
        .Reset     (Reset),
        .btn_raw   (Button_mid),
        .btn_level (btn_level)
    );

    // Only the press edge matters; release is ignored.
    assign press = btn_level & ~btn_level_q;

    // ---------------- prescaler ----------------
    state_e           state;
    state_e           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_m1;
    logic             tick;

    assign period_m1 = CNT_W'(period_cycles(BASE_DIV, speed_s) - 32'd1);
    assign tick      = (state == S_RUN) && (cnt == period_m1);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (speed_s != speed_q) begin
            // A new speed restarts the count so the new rate applies at once.
            cnt <= '0;
        end else if (state == S_RUN) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    // ---------------- mode FSM ----------------
    dir_cmd_e         dir_sel;
    dir_cmd_e         dir_sel_d;
    logic             step;
    logic             step_d;
    logic             mode;
    logic             mode_d;
    logic             dir;
    logic             dir_d;
    logic             next_dir;
    logic             at_end;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] pos_d;

    assign at_end = (pos == LAST_POS);

    // Direction taken on a tick: fixed mode follows the switch, bounce mode
    // reverses once a full sweep of NUM_LEDS-1 shifts has been made.
    assign next_dir = mode ? (at_end ? ~dir : dir) : rl_s;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state <= S_LOAD;
        else        state <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state;
        dir_sel_d = DIR_HOLD;
        step_d    = 1'b0;
        mode_d    = mode;
        dir_d     = dir;
        pos_d     = pos;

        case (state)
            S_LOAD: begin
                dir_sel_d = DIR_RELOAD;
                step_d    = 1'b1;
                pos_d     = '0;
                dir_d     = rl_s;
                // This cycle already reloads, so a press here only flips the mode
                // instead of requesting a second back-to-back RELOAD.
                if (press) mode_d = ~mode;
                state_d = pause_s ? S_PAUSE : S_RUN;
            end
            S_RUN: begin
                if (press) begin
                    mode_d  = ~mode;
                    state_d = S_LOAD;
                end else if (pause_s) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    step_d    = 1'b1;
                    dir_d     = next_dir;
                    dir_sel_d = next_dir ? DIR_SHL : DIR_SHR;
                    pos_d     = at_end ? '0 : pos + 1'b1;
                end
            end
            S_PAUSE: begin
                if (press) begin
                    mode_d  = ~mode;
                    state_d = S_LOAD;
                end else if (!pause_s) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            dir_sel <= DIR_HOLD;
            step    <= 1'b0;
            mode    <= 1'b0;
            dir     <= 1'b0;
            pos     <= '0;
        end else begin
            dir_sel <= dir_sel_d;
            step    <= step_d;
            mode    <= mode_d;
            dir     <= dir_d;
            pos     <= pos_d;
        end
    end

    assign disp.Dir_Sel = dir_sel;
    assign disp.Step    = step;
    assign disp.Mode    = mode;
    assign disp.Pos     = pos;

endmodule

// File: tb/tb_flow_light_ctrl.sv
// Self-checking bench for flow_light_ctrl: a behavioural sequencer model is
// compared every cycle, with directed scenarios pinned by literal expectations.
module tb_flow_light_ctrl;

    localparam int BASE_DIV  = 4;
    localparam int DB_CYCLES = 8;
    localparam int NUM_LEDS  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] speed_sw = 2'd3;
    logic       rl_sw = 1'b0;
    logic       pause_sw = 1'b0;
    logic       btn = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    flow_light_ctrl_if #(.NUM_LEDS(NUM_LEDS)) ifc ();

    flow_light_ctrl #(
        .BASE_DIV  (BASE_DIV),
        .DB_CYCLES (DB_CYCLES),
        .NUM_LEDS  (NUM_LEDS)
    ) dut (
        .CLK         (clk),
        .Reset       (rst_n),
        .speed       (speed_sw),
        .RLSwitch    (rl_sw),
        .PauseSwitch (pause_sw),
        .Button_mid  (btn),
        .disp        (ifc)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {LOADING, RUNNING, PAUSED} phase_t;

    phase_t m_phase;
    int m_sp1, m_sp2, m_rl1, m_rl2, m_pz1, m_pz2, m_b1, m_b2;
    int m_sp_prev, m_clean, m_clean_prev, m_run_len;
    int m_cnt, m_mode, m_dir, m_pos, e_step, e_dsel;

    function automatic void model_reset();
        m_phase = LOADING;
        m_sp1 = 0; m_sp2 = 0; m_rl1 = 0; m_rl2 = 0; m_pz1 = 0; m_pz2 = 0;
        m_b1 = 0; m_b2 = 0; m_sp_prev = 0; m_clean = 0; m_clean_prev = 0;
        m_run_len = 0; m_cnt = 0; m_mode = 0; m_dir = 0; m_pos = 0;
        e_step = 0; e_dsel = 0;
    endfunction

    function automatic void model_step();
        bit press, running, tick;
        int period;
        press   = (m_clean == 1) && (m_clean_prev == 0);
        period  = BASE_DIV << (3 - m_sp2);
        running = (m_phase == RUNNING);
        tick    = running && (m_cnt == period - 1);
        e_step  = 0;
        e_dsel  = 0;
        case (m_phase)
            LOADING: begin
                e_step = 1; e_dsel = 3; m_pos = 0; m_dir = m_rl2;
                if (press) m_mode = 1 - m_mode;
                m_phase = (m_pz2 != 0) ? PAUSED : RUNNING;
            end
            RUNNING: begin
                if (press) begin
                    m_mode = 1 - m_mode; m_phase = LOADING;
                end else if (m_pz2 != 0) begin
                    m_phase = PAUSED;
                end else if (tick) begin
                    if (m_mode == 0) m_dir = m_rl2;
                    else if (m_pos == NUM_LEDS - 1) m_dir = 1 - m_dir;
                    m_pos  = (m_pos + 1) % NUM_LEDS;
                    e_step = 1;
                    e_dsel = (m_dir != 0) ? 2 : 1;
                end
            end
            default: begin
                if (press) begin
                    m_mode = 1 - m_mode; m_phase = LOADING;
                end else if (m_pz2 == 0) begin
                    m_phase = RUNNING;
                end
            end
        endcase
        if (m_sp2 != m_sp_prev) m_cnt = 0;
        else if (running) m_cnt = tick ? 0 : m_cnt + 1;
        m_sp_prev    = m_sp2;
        m_clean_prev = m_clean;
        if (m_b2 == m_clean) m_run_len = 0;
        else begin
            m_run_len++;
            if (m_run_len == DB_CYCLES) begin
                m_clean   = m_b2;
                m_run_len = 0;
            end
        end
        m_sp2 = m_sp1; m_sp1 = int'(speed_sw);
        m_rl2 = m_rl1; m_rl1 = int'(rl_sw);
        m_pz2 = m_pz1; m_pz1 = int'(pause_sw);
        m_b2  = m_b1;  m_b1  = int'(btn);
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Every-cycle comparison of the full output bundle against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en)
            check("cycle_outputs",
                  int'({ifc.Dir_Sel, ifc.Step, ifc.Mode, ifc.Pos}),
                  (e_dsel << 6) | (e_step << 5) | (m_mode << 4) | m_pos);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_step(input int bound, output int n, output int dsel);
        n = 0;
        dsel = -1;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (ifc.Step) begin
                dsel = int'(ifc.Dir_Sel);
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL step_timeout no Step within %0d cycles at %0t", bound, $time);
    endtask

    task automatic count_steps(input int n, output int steps);
        steps = 0;
        repeat (n) begin
            @(negedge clk);
            if (ifc.Step) steps++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, d, steps, pos_hold, found;

        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        cycles(3);
        check("rst_step", int'(ifc.Step), 0);
        check("rst_dir_sel", int'(ifc.Dir_Sel), 0);
        check("rst_mode", int'(ifc.Mode), 0);
        check("rst_pos", int'(ifc.Pos), 0);

        // 1: reload first, then SHIFT_R every 4 cycles with Pos counting up.
        rst_n = 1'b1;
        wait_step(10, n, d);
        check("first_reload", d, 3);
        for (int k = 1; k <= NUM_LEDS; k++) begin
            wait_step(40, n, d);
            check("fast_dir", d, 1);
            check("fast_pos", int'(ifc.Pos), k % NUM_LEDS);
            if (k >= 2) check("fast_period", n, 4);
        end

        // 2: slowest speed, then a mid-count jump back to the fastest.
        @(posedge clk); #2;
        speed_sw = 2'd0;
        cycles(5);
        wait_step(80, n, d);
        wait_step(80, n, d);
        check("slow_period", n, 32);
        repeat (10) @(negedge clk);
        @(posedge clk); #2;
        speed_sw = 2'd3;
        wait_step(40, n, d);
        check("speed_up_latency", n, 8);

        // 3: glitch ignored, real press enters bounce mode and reverses at the end.
        @(posedge clk); #2;
        btn = 1'b1;
        cycles(5);
        btn = 1'b0;
        cycles(20);
        check("glitch_mode", int'(ifc.Mode), 0);
        btn = 1'b1;
        d = 0;
        for (int i = 0; i < 12 && d != 3; i++) wait_step(40, n, d);
        check("press_reload", d, 3);
        check("press_mode", int'(ifc.Mode), 1);
        check("press_pos", int'(ifc.Pos), 0);
        @(posedge clk); #2;
        btn = 1'b0;
        for (int k = 1; k < NUM_LEDS; k++) begin
            wait_step(40, n, d);
            check("bounce_out_dir", d, 1);
            check("bounce_out_pos", int'(ifc.Pos), k);
        end
        wait_step(40, n, d);
        check("bounce_rev_dir", d, 2);
        check("bounce_rev_pos", int'(ifc.Pos), 0);

        // 4: pause freezes everything; resume waits the remaining count.
        @(posedge clk); #2;
        pause_sw = 1'b1;
        pos_hold = int'(ifc.Pos);
        count_steps(50, steps);
        check("pause_steps", steps, 0);
        check("pause_pos", int'(ifc.Pos), pos_hold);
        @(posedge clk); #2;
        pause_sw = 1'b0;
        wait_step(40, n, d);
        check("resume_latency", n, 8);
        check("resume_dir", d, 2);

        // 5: press while paused reloads once and stays paused with Mode toggled.
        @(posedge clk); #2;
        pause_sw = 1'b1;
        cycles(5);
        btn = 1'b1;
        wait_step(40, n, d);
        check("pause_press_reload", d, 3);
        check("pause_press_mode", int'(ifc.Mode), 0);
        @(posedge clk); #2;
        btn = 1'b0;
        count_steps(40, steps);
        check("pause_press_hold", steps, 0);
        @(posedge clk); #2;
        pause_sw = 1'b0;

        // 6: asynchronous reset in the middle of a Step at Pos=9.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            wait_step(40, n, d);
            if (ifc.Pos == 4'd9) found = 1;
        end
        check("reach_pos9", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_step", int'(ifc.Step), 0);
        check("async_dir_sel", int'(ifc.Dir_Sel), 0);
        check("async_pos", int'(ifc.Pos), 0);
        cycles(2);
        rst_n = 1'b1;
        wait_step(10, n, d);
        check("post_reset_reload", d, 3);
        check("post_reset_mode", int'(ifc.Mode), 0);
        check("post_reset_pos", int'(ifc.Pos), 0);

        // Randomised phase: the per-cycle model comparison does the checking.
        for (int it = 0; it < 120; it++) begin
            case ($urandom_range(5, 0))
                0: speed_sw = 2'($urandom_range(3, 0));
                1: rl_sw = 1'($urandom_range(1, 0));
                2: begin
                    pause_sw = 1'b1;
                    cycles($urandom_range(40, 5));
                    pause_sw = 1'b0;
                end
                3: begin
                    btn = 1'b1;
                    cycles($urandom_range(30, 10));
                    btn = 1'b0;
                    cycles($urandom_range(20, 10));
                end
                4: begin
                    btn = 1'b1;
                    cycles($urandom_range(7, 1));
                    btn = 1'b0;
                end
                default: cycles($urandom_range(30, 1));
            endcase
            cycles(1);
        end
        cycles(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
